// File: rtl/pga_gain_driver.sv
// pga_gain_driver: turns the AGC gain index into a serial write to the analog
// PGA (CS/SCLK/SDI, MSB first), followed by a fixed settling interval.
// busy/blank cover the whole write plus settle; applied_gain reports the gain
// actually in effect once that settle completes.
module pga_gain_driver #(
    parameter int unsigned         CODE_W        = 8,
    parameter int unsigned         SCLK_DIV      = 4,
    parameter int unsigned         SETTLE_CYCLES = 64,
    parameter logic [4*CODE_W-1:0] GAIN_TABLE    = 32'h40_20_08_01
) (
    input  logic       adc_clk,
    input  logic       rst,
    input  logic [1:0] gain_ctrl,
    output logic       pga_cs_n,
    output logic       pga_sclk,
    output logic       pga_sdi,
    output logic       busy,
    output logic       blank,
    output logic [1:0] applied_gain
);

    localparam int unsigned CNT_MAX = (2 * SCLK_DIV > SETTLE_CYCLES) ? 2 * SCLK_DIV : SETTLE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned BIT_W   = (CODE_W > 1) ? $clog2(CODE_W) : 1;

    localparam logic [CNT_W-1:0] HALF_END   = CNT_W'(SCLK_DIV - 1);
    localparam logic [CNT_W-1:0] PERIOD_END = CNT_W'(2 * SCLK_DIV - 1);
    localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(CODE_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        HOLD,
        SETTLE
    } state_t;

    state_t            st_q, st_d;
    logic              cs_n_q, cs_n_d;
    logic              sclk_q, sclk_d;
    logic              sdi_q, sdi_d;
    logic              busy_q, busy_d;
    logic [1:0]        applied_q, applied_d;
    logic [1:0]        target_q, target_d;
    logic              init_q, init_d;
    logic [CODE_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [CODE_W-1:0] code;

    // PGA code for the requested gain index
    always_comb begin
        code = GAIN_TABLE[CODE_W-1:0];
        case (gain_ctrl)
            2'd0: code = GAIN_TABLE[CODE_W-1:0];
            2'd1: code = GAIN_TABLE[2*CODE_W-1:CODE_W];
            2'd2: code = GAIN_TABLE[3*CODE_W-1:2*CODE_W];
            2'd3: code = GAIN_TABLE[4*CODE_W-1:3*CODE_W];
            default: code = GAIN_TABLE[CODE_W-1:0];
        endcase
    end

    // Next-state and registered-output logic of the write sequencer
    always_comb begin
        st_d      = st_q;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        sdi_d     = sdi_q;
        busy_d    = busy_q;
        applied_d = applied_q;
        target_d  = target_q;
        init_d    = init_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;

        case (st_q)
            IDLE: begin
                if (init_q || (gain_ctrl != applied_q)) begin
                    target_d = gain_ctrl;
                    shreg_d  = code;
                    cs_n_d   = 1'b0;
                    sdi_d    = code[CODE_W-1];
                    busy_d   = 1'b1;
                    init_d   = 1'b0;
                    cnt_d    = '0;
                    st_d     = LOAD;
                end
            end
            LOAD: begin
                if (cnt_q == HALF_END) begin
                    cnt_d = '0;
                    bit_d = '0;
                    st_d  = SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                // cnt spans one full bit period: low half, then high half
                if (cnt_q == PERIOD_END) begin
                    sclk_d = 1'b0;
                    cnt_d  = '0;
                    if (bit_q == LAST_BIT) begin
                        sdi_d = 1'b0;
                        st_d  = HOLD;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shreg_d = shreg_q << 1;
                        sdi_d   = shreg_d[CODE_W-1];
                    end
                end else begin
                    if (cnt_q == HALF_END) begin
                        sclk_d = 1'b1;
                    end
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == HALF_END) begin
                    cs_n_d = 1'b1;
                    cnt_d  = '0;
                    st_d   = SETTLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_END) begin
                    applied_d = target_q;
                    busy_d    = 1'b0;
                    cnt_d     = '0;
                    st_d      = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge adc_clk) begin
        if (rst) begin
            st_q      <= IDLE;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            sdi_q     <= 1'b0;
            busy_q    <= 1'b0;
            applied_q <= '0;
            target_q  <= '0;
            init_q    <= 1'b1;
            shreg_q   <= '0;
            cnt_q     <= '0;
            bit_q     <= '0;
        end else begin
            st_q      <= st_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            sdi_q     <= sdi_d;
            busy_q    <= busy_d;
            applied_q <= applied_d;
            target_q  <= target_d;
            init_q    <= init_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
        end
    end

    assign pga_cs_n     = cs_n_q;
    assign pga_sclk     = sclk_q;
    assign pga_sdi      = sdi_q;
    assign busy         = busy_q;
    assign blank        = busy_q;
    assign applied_gain = applied_q;

endmodule

// File: tb/tb_pga_gain_driver.sv
// Bench for pga_gain_driver: a bus monitor decodes each serial write into a
// transaction (code, CS length, SCLK rises, timing faults) and each busy
// window into (length, applied gain, preceding idle gap); scenario tasks
// compare those against values derived from the gain table and timing rules.
module tb_pga_gain_driver;

    logic       clk = 1'b0;
    logic       rst, rst_f;
    logic [1:0] gain, gain_f;
    logic       cs_n0, sclk0, sdi0, busy0, blank0;
    logic [1:0] app0;
    logic       cs_n1, sclk1, sdi1, busy1, blank1;
    logic [1:0] app1;

    always #5 clk = ~clk;

    pga_gain_driver dut (
        .adc_clk(clk), .rst(rst), .gain_ctrl(gain),
        .pga_cs_n(cs_n0), .pga_sclk(sclk0), .pga_sdi(sdi0),
        .busy(busy0), .blank(blank0), .applied_gain(app0)
    );

    pga_gain_driver #(.SCLK_DIV(1), .SETTLE_CYCLES(1)) dut_fast (
        .adc_clk(clk), .rst(rst_f), .gain_ctrl(gain_f),
        .pga_cs_n(cs_n1), .pga_sclk(sclk1), .pga_sdi(sdi1),
        .busy(busy1), .blank(blank1), .applied_gain(app1)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] code_tab [4] = '{8'h01, 8'h08, 8'h20, 8'h40};

    typedef struct { logic [7:0] code; int cs_len; int rises; int bad; } wrec_t;
    typedef struct { int len; logic [1:0] app; int gap; } brec_t;
    wrec_t wq0[$], wq1[$];
    brec_t bq0[$], bq1[$];

    // monitor state, one slot per DUT
    int         dval[2] = '{4, 1};
    int         cs_cnt[2], rise_cnt[2], bad[2], last_chg[2], last_rise[2];
    int         busy_cnt[2], idle_cnt[2], gap[2], stray[2], blank_bad[2];
    logic [7:0] acc[2];
    logic       p_cs[2], p_sclk[2], p_sdi[2], p_busy[2];
    bit         mon_en = 1'b0;
    logic       m_cs, m_sc, m_sd, m_bs, m_bl;
    logic [1:0] m_ap;
    int         off;
    wrec_t      mw;
    brec_t      mb;

    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            for (int u = 0; u < 2; u++) begin
                if (u == 0) begin
                    m_cs = cs_n0; m_sc = sclk0; m_sd = sdi0; m_bs = busy0; m_bl = blank0; m_ap = app0;
                end else begin
                    m_cs = cs_n1; m_sc = sclk1; m_sd = sdi1; m_bs = busy1; m_bl = blank1; m_ap = app1;
                end
                if (m_cs === 1'b0) begin
                    if (p_cs[u]) begin
                        cs_cnt[u] = 0; rise_cnt[u] = 0; acc[u] = 8'h00;
                        bad[u] = 0; last_chg[u] = 0; last_rise[u] = -100;
                    end
                    off = cs_cnt[u];
                    cs_cnt[u]++;
                    if (m_sd !== p_sdi[u]) begin
                        if (m_sc) bad[u]++;
                        last_chg[u] = off;
                    end
                    if (m_sc && !p_sclk[u]) begin
                        if (off != 2 * dval[u] + 2 * dval[u] * rise_cnt[u]) bad[u]++;
                        if (off - last_chg[u] < dval[u]) bad[u]++;
                        acc[u] = {acc[u][6:0], m_sd};
                        rise_cnt[u]++;
                        last_rise[u] = off;
                    end
                    if (!m_sc && p_sclk[u]) begin
                        if (off - last_rise[u] != dval[u]) bad[u]++;
                    end
                end else begin
                    if (m_sc !== 1'b0) stray[u]++;
                    if (!p_cs[u]) begin
                        mw = '{acc[u], cs_cnt[u], rise_cnt[u], bad[u]};
                        if (u == 0) wq0.push_back(mw); else wq1.push_back(mw);
                    end
                end
                if (m_bl !== m_bs) blank_bad[u]++;
                if (m_bs === 1'b1) begin
                    if (!p_busy[u]) begin
                        gap[u] = idle_cnt[u];
                        busy_cnt[u] = 0;
                    end
                    busy_cnt[u]++;
                end else begin
                    if (p_busy[u]) begin
                        mb = '{busy_cnt[u], m_ap, gap[u]};
                        if (u == 0) bq0.push_back(mb); else bq1.push_back(mb);
                        idle_cnt[u] = 1;
                    end else begin
                        idle_cnt[u]++;
                    end
                end
                p_cs[u] = (m_cs !== 1'b0);
                p_sclk[u] = (m_sc === 1'b1);
                p_sdi[u] = m_sd;
                p_busy[u] = (m_bs === 1'b1);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic flush();
        wq0.delete(); wq1.delete(); bq0.delete(); bq1.delete();
    endtask

    task automatic wait_busy_rec(input int u, input int limit);
        int n = 0;
        while (((u == 0) ? bq0.size() : bq1.size()) == 0 && n < limit) begin
            tick(1);
            n++;
        end
        checks++;
        if (((u == 0) ? bq0.size() : bq1.size()) == 0) begin
            errors++;
            $display("FAIL busy_done_u%0d: no completion after %0d cycles, expected one", u, limit);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rst_f = 1'b1; gain = 2'd0; gain_f = 2'd3;
        tick(3);
        checks++; if (cs_n0 !== 1'b1) begin errors++; $display("FAIL rst_cs_n: got %b expected 1", cs_n0); end
        checks++; if (sclk0 !== 1'b0) begin errors++; $display("FAIL rst_sclk: got %b expected 0", sclk0); end
        checks++; if (sdi0 !== 1'b0) begin errors++; $display("FAIL rst_sdi: got %b expected 0", sdi0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy0); end
        checks++; if (blank0 !== 1'b0) begin errors++; $display("FAIL rst_blank: got %b expected 0", blank0); end
        checks++; if (app0 !== 2'd0) begin errors++; $display("FAIL rst_applied: got %0d expected 0", app0); end
        checks++; if (cs_n1 !== 1'b1 || busy1 !== 1'b0) begin errors++; $display("FAIL rst_fast: got cs_n=%b busy=%b expected 1/0", cs_n1, busy1); end
        for (int u = 0; u < 2; u++) begin
            p_cs[u] = 1'b1; p_sclk[u] = 1'b0; p_sdi[u] = 1'b0; p_busy[u] = 1'b0;
            stray[u] = 0; blank_bad[u] = 0; idle_cnt[u] = 0; gap[u] = 0;
        end
        mon_en = 1'b1;
    endtask

    task automatic test_init_write();
        wrec_t w; brec_t b;
        flush();
        rst = 1'b0;
        tick(1);
        checks++; if (cs_n0 !== 1'b0) begin errors++; $display("FAIL init_start: got cs_n=%b expected 0", cs_n0); end
        wait_busy_rec(0, 400);
        checks++; if (wq0.size() != 1) begin errors++; $display("FAIL init_count: got %0d writes expected 1", wq0.size()); end
        w = '{8'h00, 0, 0, 0}; if (wq0.size() != 0) w = wq0.pop_front();
        b = '{0, 2'd0, 0};     if (bq0.size() != 0) b = bq0.pop_front();
        checks++; if (w.code !== 8'h01) begin errors++; $display("FAIL init_code: got %h expected 01", w.code); end
        checks++; if (w.cs_len != 72) begin errors++; $display("FAIL init_cs_len: got %0d expected 72", w.cs_len); end
        checks++; if (w.rises != 8) begin errors++; $display("FAIL init_rises: got %0d expected 8", w.rises); end
        checks++; if (w.bad != 0) begin errors++; $display("FAIL init_timing: got %0d faults expected 0", w.bad); end
        checks++; if (b.len != 136) begin errors++; $display("FAIL init_busy_len: got %0d expected 136", b.len); end
        checks++; if (b.app !== 2'd0) begin errors++; $display("FAIL init_applied: got %0d expected 0", b.app); end
    endtask

    task automatic test_change();
        wrec_t w; brec_t b;
        flush();
        tick(5);
        gain = 2'd2;
        tick(1);
        checks++; if (cs_n0 !== 1'b0 || busy0 !== 1'b1) begin errors++; $display("FAIL chg_latency: got cs_n=%b busy=%b expected 0/1", cs_n0, busy0); end
        wait_busy_rec(0, 400);
        w = '{8'h00, 0, 0, 0}; if (wq0.size() != 0) w = wq0.pop_front();
        b = '{0, 2'd0, 0};     if (bq0.size() != 0) b = bq0.pop_front();
        checks++; if (w.code !== 8'h20) begin errors++; $display("FAIL chg_code: got %h expected 20", w.code); end
        checks++; if (w.bad != 0 || w.rises != 8) begin errors++; $display("FAIL chg_timing: got faults=%0d rises=%0d expected 0/8", w.bad, w.rises); end
        checks++; if (b.len != 136) begin errors++; $display("FAIL chg_busy_len: got %0d expected 136", b.len); end
        checks++; if (b.app !== 2'd2) begin errors++; $display("FAIL chg_applied: got %0d expected 2", b.app); end
    endtask

    task automatic test_last_wins();
        brec_t b1, b2;
        gain = 2'd0;
        wait_busy_rec(0, 400);
        tick(3);
        flush();
        gain = 2'd2;
        tick(20);
        gain = 2'd3;
        tick(20);
        gain = 2'd1;
        wait_busy_rec(0, 400);
        b1 = '{0, 2'd0, 0}; if (bq0.size() != 0) b1 = bq0.pop_front();
        wait_busy_rec(0, 400);
        b2 = '{0, 2'd0, 0}; if (bq0.size() != 0) b2 = bq0.pop_front();
        tick(50);
        checks++; if (wq0.size() != 2) begin errors++; $display("FAIL lw_count: got %0d writes expected 2", wq0.size()); end
        checks++; if (wq0.size() > 0 && wq0[0].code !== 8'h20) begin errors++; $display("FAIL lw_first: got %h expected 20", wq0[0].code); end
        checks++; if (wq0.size() > 1 && wq0[1].code !== 8'h08) begin errors++; $display("FAIL lw_second: got %h expected 08", wq0[1].code); end
        checks++; if (b1.app !== 2'd2) begin errors++; $display("FAIL lw_mid_applied: got %0d expected 2", b1.app); end
        checks++; if (b2.gap != 1) begin errors++; $display("FAIL lw_gap: got %0d idle cycles expected 1", b2.gap); end
        checks++; if (app0 !== 2'd1) begin errors++; $display("FAIL lw_applied: got %0d expected 1", app0); end
    endtask

    task automatic test_revert();
        flush();
        gain = 2'd2;
        tick(30);
        gain = 2'd3;
        tick(30);
        gain = 2'd2;
        wait_busy_rec(0, 400);
        tick(200);
        checks++; if (wq0.size() != 1 || bq0.size() != 1) begin errors++; $display("FAIL rev_count: got %0d writes %0d busy windows expected 1/1", wq0.size(), bq0.size()); end
        checks++; if (wq0.size() > 0 && wq0[0].code !== 8'h20) begin errors++; $display("FAIL rev_code: got %h expected 20", wq0[0].code); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rev_busy: got %b expected 0", busy0); end
        checks++; if (app0 !== 2'd2) begin errors++; $display("FAIL rev_applied: got %0d expected 2", app0); end
    endtask

    task automatic test_reset_mid();
        wrec_t w; brec_t b;
        flush();
        gain = 2'd1;
        tick(30);
        checks++; if (cs_n0 !== 1'b0) begin errors++; $display("FAIL rm_in_write: got cs_n=%b expected 0", cs_n0); end
        rst = 1'b1;
        tick(1);
        checks++; if (cs_n0 !== 1'b1) begin errors++; $display("FAIL rm_cs_n: got %b expected 1", cs_n0); end
        checks++; if (sclk0 !== 1'b0) begin errors++; $display("FAIL rm_sclk: got %b expected 0", sclk0); end
        checks++; if (busy0 !== 1'b0 || blank0 !== 1'b0) begin errors++; $display("FAIL rm_busy: got busy=%b blank=%b expected 0/0", busy0, blank0); end
        checks++; if (app0 !== 2'd0) begin errors++; $display("FAIL rm_applied: got %0d expected 0", app0); end
        rst = 1'b0;
        flush();
        wait_busy_rec(0, 400);
        w = '{8'h00, 0, 0, 0}; if (wq0.size() != 0) w = wq0.pop_front();
        b = '{0, 2'd0, 0};     if (bq0.size() != 0) b = bq0.pop_front();
        checks++; if (w.code !== 8'h08) begin errors++; $display("FAIL rm_code: got %h expected 08", w.code); end
        checks++; if (w.cs_len != 72 || w.bad != 0) begin errors++; $display("FAIL rm_timing: got cs_len=%0d faults=%0d expected 72/0", w.cs_len, w.bad); end
        checks++; if (b.len != 136 || b.app !== 2'd1) begin errors++; $display("FAIL rm_busy_len: got len=%0d applied=%0d expected 136/1", b.len, b.app); end
    endtask

    task automatic test_random();
        int         model_app = 1;
        logic [7:0] exp_q[$];
        int         g1, g2, f, n;
        tick(5);
        for (int it = 0; it < 8; it++) begin
            flush();
            exp_q.delete();
            g1 = $urandom_range(0, 3);
            f = g1;
            gain = 2'(g1);
            if (g1 != model_app) begin
                exp_q.push_back(code_tab[g1]);
                tick($urandom_range(5, 100));
                g2 = $urandom_range(0, 3);
                gain = 2'(g2);
                f = g2;
                if (g2 != g1) exp_q.push_back(code_tab[g2]);
            end
            n = 0;
            tick(1);
            while ((wq0.size() < exp_q.size() || busy0 !== 1'b0) && n < 1000) begin
                tick(1);
                n++;
            end
            tick(20);
            checks++;
            if (wq0.size() != exp_q.size()) begin
                errors++;
                $display("FAIL rnd_count[%0d]: got %0d writes expected %0d", it, wq0.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < wq0.size(); i++) begin
                checks++;
                if (wq0[i].code !== exp_q[i] || wq0[i].bad != 0) begin
                    errors++;
                    $display("FAIL rnd_code[%0d.%0d]: got %h faults=%0d expected %h faults=0", it, i, wq0[i].code, wq0[i].bad, exp_q[i]);
                end
            end
            checks++;
            if (app0 !== 2'(f)) begin errors++; $display("FAIL rnd_applied[%0d]: got %0d expected %0d", it, app0, f); end
            model_app = f;
        end
    endtask

    task automatic test_fast();
        wrec_t w; brec_t b;
        flush();
        rst_f = 1'b0;
        wait_busy_rec(1, 100);
        w = '{8'h00, 0, 0, 0}; if (wq1.size() != 0) w = wq1.pop_front();
        b = '{0, 2'd0, 0};     if (bq1.size() != 0) b = bq1.pop_front();
        checks++; if (w.code !== 8'h40) begin errors++; $display("FAIL fast_code: got %h expected 40", w.code); end
        checks++; if (w.cs_len != 18) begin errors++; $display("FAIL fast_cs_len: got %0d expected 18", w.cs_len); end
        checks++; if (w.rises != 8 || w.bad != 0) begin errors++; $display("FAIL fast_timing: got rises=%0d faults=%0d expected 8/0", w.rises, w.bad); end
        checks++; if (b.len != 19) begin errors++; $display("FAIL fast_busy_len: got %0d expected 19", b.len); end
        checks++; if (b.app !== 2'd3) begin errors++; $display("FAIL fast_applied: got %0d expected 3", b.app); end
    endtask

    task automatic test_bus_hygiene();
        for (int u = 0; u < 2; u++) begin
            checks++; if (stray[u] != 0) begin errors++; $display("FAIL sclk_outside_cs_u%0d: got %0d cycles expected 0", u, stray[u]); end
            checks++; if (blank_bad[u] != 0) begin errors++; $display("FAIL blank_vs_busy_u%0d: got %0d cycles differing expected 0", u, blank_bad[u]); end
        end
    endtask

    initial begin
        test_reset();
        test_init_write();
        test_change();
        test_last_wins();
        test_revert();
        test_reset_mid();
        test_random();
        test_fast();
        test_bus_hygiene();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
